// File: rtl/dir_bus_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
// Imported by the interface, the grant picker and the top level.
package dir_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } dir_bus_state_e;

  localparam int DIR_BUS_DATA_W = 8;

  function automatic int rr_next(
    input int ptr,
    input int n
  );
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/dir_bus_arbiter_if.sv
// Writer/reader handshake bundle of the shared bus.
// Only the arbiter (slave side) drives the bus data.
interface dir_bus_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [SRC_W-1:0]          out_src;
  logic                      out_ready;
  logic                      busy;

  modport master (
    output req_valid,
    output req_data,
    output out_ready,
    input  req_ready,
    input  out_valid,
    input  out_data,
    input  out_src,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  out_ready,
    output req_ready,
    output out_valid,
    output out_data,
    output out_src,
    output busy
  );

endinterface

// File: rtl/dir_bus_rr_pick.sv
// Combinational round-robin picker: first request after rr_ptr,
// found by a priority search over the request vector doubled up.
module dir_bus_rr_pick
  import dir_bus_pkg::*;
#(
  parameter int N     = 4,
  parameter int SRC_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SRC_W-1:0] rr_ptr,
  output logic [N-1:0]     grant,
  output logic [SRC_W-1:0] idx,
  output logic             any
);

  logic [2*N-1:0] dbl;
  int             start;

  always_comb begin
    dbl   = {req, req};
    start = rr_next(int'(rr_ptr), N);
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < 2 * N; k++) begin
      if (!any && (k >= start) && dbl[k]) begin
        any = 1'b1;
        idx = SRC_W'(k % N);
      end
    end
    if (any) begin
      grant[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/dir_bus_arbiter.sv
// Round-robin arbiter sharing one output register among NUM_REQ writers.
// Refills in the same cycle the reader drains, so no bubbles.
module dir_bus_arbiter
  import dir_bus_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DIR_BUS_DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  dir_bus_arbiter_if.slave bus
);

  localparam int SRC_W = $clog2(NUM_REQ);

  dir_bus_state_e    state_q, state_d;
  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SRC_W-1:0]  out_src_q, out_src_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [SRC_W-1:0]   pick_idx;
  logic               pick_any;
  logic               can_load;
  logic               load;

  dir_bus_rr_pick #(
    .N     (NUM_REQ),
    .SRC_W (SRC_W)
  ) u_pick (
    .req    (bus.req_valid),
    .rr_ptr (rr_ptr_q),
    .grant  (pick_grant),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign can_load = (state_q == IDLE) ||
                    ((state_q == FULL) && bus.out_ready);
  assign load     = can_load && pick_any;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= SRC_W'(NUM_REQ - 1);
      out_data_q <= '0;
      out_src_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) state_d = FULL;
      end
      FULL: begin
        if (bus.out_ready && !pick_any) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Pointer moves only on an actual grant.
    if (load) begin
      rr_ptr_d   = pick_idx;
      out_src_d  = pick_idx;
      out_data_d = bus.req_data[pick_idx*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    bus.out_valid = (state_q == FULL);
    bus.out_data  = out_data_q;
    bus.out_src   = out_src_q;
    bus.req_ready = (load && !rst) ? pick_grant : '0;
    bus.busy      = (state_q == FULL) || (|bus.req_valid);
  end

endmodule
